// File: rtl/gaussian_stream_ctrl.sv
// Sequencer for the 3-line Gaussian filter: loads three line buffers from PCIe
// streams, reads them into the filter pipeline, buffers results and raises an interrupt.
module gaussian_stream_ctrl #(
   parameter int LINE_WORDS = 64,
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 64,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  i_user_clk,
   input  logic                  i_rst,
   input  logic                  i_user_wr_req,
   input  logic                  i_user_rd_req,
   input  logic [19:0]           i_user_addr,
   input  logic [31:0]           i_user_data,
   output logic [31:0]           o_user_data,
   output logic                  o_user_rd_ack,
   input  logic [2:0]            i_str_valid,
   output logic [2:0]            o_str_ack,
   output logic [2:0]            o_lbuf_wr_en,
   output logic [3*ADDR_W-1:0]   o_lbuf_wr_addr,
   output logic                  o_lbuf_rd_en,
   output logic [ADDR_W-1:0]     o_lbuf_rd_addr,
   input  logic                  i_filt_valid,
   input  logic [DATA_W-1:0]     i_filt_data,
   output logic                  o_out_valid,
   output logic [DATA_W-1:0]     o_out_data,
   input  logic                  i_out_ack,
   output logic                  o_intr_req,
   input  logic                  i_intr_ack
);

   localparam int CNT_W = ADDR_W + 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int IF_W  = PTR_W + 1;
   localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(LINE_WORDS - 1);
   localparam logic [CNT_W-1:0] LINE_CNT  = CNT_W'(LINE_WORDS);
   localparam logic [IF_W:0]    DEPTH_SUM = (IF_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, INTR} state_t;

   state_t                     state, state_nxt;
   logic [2:0]                 full;
   logic [2:0][CNT_W-1:0]      wcnt;
   logic [CNT_W-1:0]           rd_addr;
   logic [CNT_W-1:0]           out_cnt;
   logic [IF_W-1:0]            inflight;
   logic [IF_W-1:0]            fifo_count;
   logic [PTR_W-1:0]           wr_ptr, rd_ptr;
   logic [DATA_W-1:0]          fifo_mem [FIFO_DEPTH];
   logic                       done, err;
   logic                       start_req, start_ok, intr_done;
   logic                       issue, push, pop, overflow, fifo_full, fifo_empty;
   logic [31:0]                status_word;
   logic                       unused_bits;

   assign unused_bits = ^{i_user_addr[19:4], i_user_addr[1:0], i_user_data[31:1]};

   assign start_req  = i_user_wr_req && (i_user_addr[3:2] == 2'd0) && i_user_data[0];
   assign start_ok   = start_req && (state == IDLE) && (full == 3'b111);
   assign intr_done  = (state == INTR) && i_intr_ack;
   assign fifo_full  = (fifo_count == IF_W'(FIFO_DEPTH));
   assign fifo_empty = (fifo_count == '0);
   assign push       = i_filt_valid && !fifo_full;
   assign overflow   = i_filt_valid && fifo_full;
   assign pop        = o_out_valid && i_out_ack;
   assign issue      = o_lbuf_rd_en;

   // Stream acks are gated by reset so every output reads 0 while it is held
   assign o_str_ack      = ((state == IDLE) && !i_rst) ? ~full : 3'b000;
   assign o_lbuf_wr_en   = i_str_valid & o_str_ack;
   assign o_lbuf_rd_en   = (state == RUN) &&
                           (({1'b0, inflight} + {1'b0, fifo_count}) < DEPTH_SUM);
   assign o_lbuf_rd_addr = rd_addr[ADDR_W-1:0];
   assign o_out_valid    = !fifo_empty;
   assign o_out_data     = fifo_empty ? '0 : fifo_mem[rd_ptr];
   assign o_intr_req     = (state == INTR);

   for (genvar k = 0; k < 3; k++) begin : g_waddr
      assign o_lbuf_wr_addr[k*ADDR_W +: ADDR_W] = wcnt[k][ADDR_W-1:0];
   end

   assign status_word = {25'd0, full, 1'b0, err, done, (state != IDLE)};

   always_ff @(posedge i_user_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (start_ok) state_nxt = RUN;
         RUN:   if (issue && (rd_addr == LAST_ADDR)) state_nxt = DRAIN;
         DRAIN: if ((out_cnt == LINE_CNT) && (inflight == '0)) state_nxt = INTR;
         INTR:  if (i_intr_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Each line counter holds at the last address once its line is full
   always_ff @(posedge i_user_clk or posedge i_rst) begin
      if (i_rst) begin
         full <= '0;
         wcnt <= '0;
      end else if (intr_done) begin
         full <= '0;
         wcnt <= '0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (o_lbuf_wr_en[k]) begin
               if (wcnt[k] == LAST_ADDR) full[k] <= 1'b1;
               else                      wcnt[k] <= wcnt[k] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge i_user_clk or posedge i_rst) begin
      if (i_rst) begin
         rd_addr  <= '0;
         inflight <= '0;
      end else begin
         if (start_ok)   rd_addr <= '0;
         else if (issue) rd_addr <= rd_addr + CNT_W'(1);
         unique case ({issue, i_filt_valid})
            2'b10:   inflight <= inflight + IF_W'(1);
            2'b01:   if (inflight != '0) inflight <= inflight - IF_W'(1);
            default: inflight <= inflight;
         endcase
      end
   end

   always_ff @(posedge i_user_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   fifo_count <= fifo_count + IF_W'(1);
            2'b01:   fifo_count <= fifo_count - IF_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge i_user_clk) begin
      if (push) fifo_mem[wr_ptr] <= i_filt_data;
   end

   // A rejected start or a dropped filter word leaves err set until the next good start
   always_ff @(posedge i_user_clk or posedge i_rst) begin
      if (i_rst) begin
         done    <= 1'b0;
         err     <= 1'b0;
         out_cnt <= '0;
      end else if (start_ok) begin
         done    <= 1'b0;
         err     <= 1'b0;
         out_cnt <= '0;
      end else begin
         if (start_req || overflow) err <= 1'b1;
         if (pop)                   out_cnt <= out_cnt + CNT_W'(1);
         if (intr_done)             done <= 1'b1;
      end
   end

   always_ff @(posedge i_user_clk or posedge i_rst) begin
      if (i_rst) begin
         o_user_rd_ack <= 1'b0;
         o_user_data   <= '0;
      end else begin
         o_user_rd_ack <= i_user_rd_req;
         if (i_user_rd_req) begin
            unique case (i_user_addr[3:2])
               2'd1:    o_user_data <= status_word;
               2'd2:    o_user_data <= 32'(out_cnt);
               default: o_user_data <= '0;
            endcase
         end else begin
            o_user_data <= '0;
         end
      end
   end

endmodule

// File: tb/tb_gaussian_stream_ctrl.sv
// Self-checking bench for gaussian_stream_ctrl: table-driven register/load scenarios
// plus randomized runs checked cycle by cycle against a credit/ordering model.
module tb_gaussian_stream_ctrl;

   localparam int LW  = 64;
   localparam int AW  = 6;
   localparam int DW  = 64;
   localparam int FD  = 8;
   localparam int LAT = 3;

   logic            clk = 1'b0;
   logic            i_rst;
   logic            i_user_wr_req, i_user_rd_req;
   logic [19:0]     i_user_addr;
   logic [31:0]     i_user_data;
   logic [31:0]     o_user_data;
   logic            o_user_rd_ack;
   logic [2:0]      i_str_valid, o_str_ack, o_lbuf_wr_en;
   logic [3*AW-1:0] o_lbuf_wr_addr;
   logic            o_lbuf_rd_en;
   logic [AW-1:0]   o_lbuf_rd_addr;
   logic            i_filt_valid;
   logic [DW-1:0]   i_filt_data;
   logic            o_out_valid;
   logic [DW-1:0]   o_out_data;
   logic            i_out_ack;
   logic            o_intr_req;
   logic            i_intr_ack;

   gaussian_stream_ctrl #(
      .LINE_WORDS(LW), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)
   ) dut (
      .i_user_clk(clk), .i_rst(i_rst),
      .i_user_wr_req(i_user_wr_req), .i_user_rd_req(i_user_rd_req),
      .i_user_addr(i_user_addr), .i_user_data(i_user_data),
      .o_user_data(o_user_data), .o_user_rd_ack(o_user_rd_ack),
      .i_str_valid(i_str_valid), .o_str_ack(o_str_ack),
      .o_lbuf_wr_en(o_lbuf_wr_en), .o_lbuf_wr_addr(o_lbuf_wr_addr),
      .o_lbuf_rd_en(o_lbuf_rd_en), .o_lbuf_rd_addr(o_lbuf_rd_addr),
      .i_filt_valid(i_filt_valid), .i_filt_data(i_filt_data),
      .o_out_valid(o_out_valid), .o_out_data(o_out_data), .i_out_ack(i_out_ack),
      .o_intr_req(o_intr_req), .i_intr_ack(i_intr_ack)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: counts of words per line and per run, not the DUT's registers
   int          m_loaded [3];
   bit          m_busy, m_done, m_err, m_intr;
   int          m_issued, m_popped, m_returned, m_outcnt;
   bit          pend_rd;
   logic [31:0] pend_val;
   bit          pipe_v [LAT];
   int          pipe_a [LAT];
   int          ack_mode;
   logic [63:0] salt;

   typedef struct {
      logic [2:0]  mask;
      int          cycles;
      int          start_mode;
      logic [31:0] exp_status;
   } vec_t;
   vec_t tbl [5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] filt_result(input int a);
      return salt ^ (64'(a) * 64'h9E3779B97F4A7C15);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) m_loaded[k] = 0;
      m_busy = 0; m_done = 0; m_err = 0; m_intr = 0;
      m_issued = 0; m_popped = 0; m_returned = 0; m_outcnt = 0;
      pend_rd = 0; pend_val = '0;
      for (int i = 0; i < LAT; i++) begin pipe_v[i] = 0; pipe_a[i] = 0; end
   endtask

   task automatic check_output();
      logic [31:0] exp_status;
      logic [2:0]  exp_ack, exp_wr;
      bit          exp_rd, exp_ov, pop, start_req, start_ok, all_full, goto_intr, intr_fin;
      all_full = (m_loaded[0] == LW) && (m_loaded[1] == LW) && (m_loaded[2] == LW);
      exp_status = {25'd0, m_loaded[2] == LW, m_loaded[1] == LW, m_loaded[0] == LW,
                    1'b0, m_err, m_done, m_busy};
      chk("rd_ack", o_user_rd_ack, pend_rd);
      if (pend_rd) chk("rd_data", o_user_data, pend_val);
      pend_rd = i_user_rd_req;
      if (i_user_rd_req)
         case (i_user_addr[3:2])
            2'd1:    pend_val = exp_status;
            2'd2:    pend_val = 32'(m_outcnt);
            default: pend_val = '0;
         endcase
      for (int k = 0; k < 3; k++) exp_ack[k] = !m_busy && (m_loaded[k] < LW);
      exp_wr = i_str_valid & exp_ack;
      chk("str_ack", o_str_ack, exp_ack);
      chk("wr_en", o_lbuf_wr_en, exp_wr);
      for (int k = 0; k < 3; k++)
         if (exp_wr[k]) chk($sformatf("wr_addr%0d", k), o_lbuf_wr_addr[k*AW +: AW], m_loaded[k]);
      exp_rd = m_busy && (m_issued < LW) && ((m_issued - m_popped) < FD);
      chk("rd_en", o_lbuf_rd_en, exp_rd);
      if (o_lbuf_rd_en && exp_rd) chk("rd_addr", o_lbuf_rd_addr, m_issued);
      exp_ov = m_returned > m_popped;
      chk("out_valid", o_out_valid, exp_ov);
      pop = exp_ov && o_out_valid && i_out_ack;
      if (pop) chk("out_data", o_out_data, filt_result(m_popped));
      chk("intr_req", o_intr_req, m_intr);

      start_req = i_user_wr_req && (i_user_addr[3:2] == 2'd0) && i_user_data[0];
      start_ok  = start_req && !m_busy && all_full;
      goto_intr = m_busy && !m_intr && (m_outcnt == LW);
      intr_fin  = m_intr && i_intr_ack;
      if (i_filt_valid) m_returned++;
      if (o_lbuf_rd_en) m_issued++;
      for (int i = LAT - 1; i > 0; i--) begin pipe_v[i] = pipe_v[i-1]; pipe_a[i] = pipe_a[i-1]; end
      pipe_v[0] = o_lbuf_rd_en;
      pipe_a[0] = int'(o_lbuf_rd_addr);
      if (pop) begin m_popped++; m_outcnt++; end
      for (int k = 0; k < 3; k++) if (exp_wr[k]) m_loaded[k]++;
      if (start_ok) begin
         m_busy = 1; m_done = 0; m_err = 0; m_outcnt = 0;
         m_issued = 0; m_popped = 0; m_returned = 0;
      end else if (start_req) begin
         m_err = 1;
      end
      if (intr_fin) begin
         m_intr = 0; m_busy = 0; m_done = 1;
         for (int k = 0; k < 3; k++) m_loaded[k] = 0;
      end else if (goto_intr) begin
         m_intr = 1;
      end
   endtask

   // One clock cycle: called at posedge+1 with the caller's inputs already driven
   task automatic apply_stimulus();
      i_filt_valid = pipe_v[LAT-1];
      i_filt_data  = pipe_v[LAT-1] ? filt_result(pipe_a[LAT-1]) : '0;
      case (ack_mode)
         0:       i_out_ack = 1'b1;
         1:       i_out_ack = 1'($urandom_range(0, 1));
         default: i_out_ack = 1'b0;
      endcase
      #1;
      check_output();
      @(posedge clk);
      #1;
   endtask

   task automatic reg_write(input logic [19:0] a, input logic [31:0] d);
      i_user_wr_req = 1'b1; i_user_addr = a; i_user_data = d;
      apply_stimulus();
      i_user_wr_req = 1'b0; i_user_data = '0;
   endtask

   task automatic reg_read(input logic [19:0] a, output logic [31:0] v);
      i_user_rd_req = 1'b1; i_user_addr = a;
      apply_stimulus();
      i_user_rd_req = 1'b0;
      v = o_user_data;
      apply_stimulus();
   endtask

   task automatic load(input logic [2:0] mask, input int n, input int start_mode);
      for (int i = 0; i < n; i++) begin
         i_str_valid = mask;
         if (start_mode == 2 && i == n - 1) begin
            i_user_wr_req = 1'b1; i_user_addr = '0; i_user_data = 32'h1;
         end
         apply_stimulus();
         i_user_wr_req = 1'b0; i_user_data = '0;
      end
      i_str_valid = '0;
      if (start_mode == 1) reg_write(20'h0, 32'h1);
   endtask

   task automatic finish_run(input int budget);
      logic [31:0] v;
      int i = 0;
      while (!o_intr_req && i < budget) begin apply_stimulus(); i++; end
      chk("intr_timeout", o_intr_req, 1'b1);
      i_intr_ack = 1'b1;
      apply_stimulus();
      i_intr_ack = 1'b0;
      chk("words_out", m_popped, LW);
      reg_read(20'h4, v);
      chk("status_done", v, 32'h02);
      reg_read(20'h8, v);
      chk("outcnt", v, LW);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] v;
      int          guard;
      i_rst = 1'b1;
      i_user_wr_req = 0; i_user_rd_req = 0; i_user_addr = '0; i_user_data = '0;
      i_str_valid = '0; i_filt_valid = 0; i_filt_data = '0; i_out_ack = 0; i_intr_ack = 0;
      ack_mode = 0;
      salt = {$urandom, $urandom};
      model_reset();
      tbl[0] = '{3'b001, 70, 0, 32'h10};
      tbl[1] = '{3'b010, 64, 1, 32'h34};
      tbl[2] = '{3'b100, 63, 0, 32'h34};
      tbl[3] = '{3'b100,  1, 2, 32'h74};
      tbl[4] = '{3'b000,  0, 1, 32'h71};

      @(posedge clk); @(posedge clk); #1;
      chk("reset_outputs", 64'(|{o_user_data, o_user_rd_ack, o_str_ack, o_lbuf_wr_en,
          o_lbuf_wr_addr, o_lbuf_rd_en, o_lbuf_rd_addr, o_out_valid, o_out_data, o_intr_req}), 0);
      i_rst = 1'b0;

      $display("[TB] table: overrun, early start, start on final word, good start");
      for (int t = 0; t < 5; t++) begin
         load(tbl[t].mask, tbl[t].cycles, tbl[t].start_mode);
         reg_read(20'h4, v);
         chk($sformatf("tbl_status%0d", t), v, tbl[t].exp_status);
      end
      finish_run(2000);

      $display("[TB] randomized load and output with backpressure window");
      salt = {$urandom, $urandom};
      ack_mode = 1;
      guard = 0;
      while (!(m_loaded[0] == LW && m_loaded[1] == LW && m_loaded[2] == LW) && guard < 1000) begin
         i_str_valid = 3'($urandom_range(0, 7));
         apply_stimulus();
         guard++;
      end
      i_str_valid = '0;
      chk("load_timeout", guard < 1000, 1'b1);
      reg_write(20'h0, 32'h1);
      guard = 0;
      while (m_issued < 20 && guard < 500) begin apply_stimulus(); guard++; end
      ack_mode = 2;
      for (int i = 0; i < 50; i++) apply_stimulus();
      chk("bp_credit", m_issued - m_popped, FD);
      ack_mode = 1;
      finish_run(3000);

      $display("[TB] reset in the middle of a run");
      ack_mode = 0;
      load(3'b111, LW, 1);
      guard = 0;
      while (m_issued < 20 && guard < 500) begin apply_stimulus(); guard++; end
      chk("run_progress", m_issued >= 20, 1'b1);
      i_rst = 1'b1; i_str_valid = 3'b111; i_filt_valid = 1'b0; i_filt_data = '0;
      #1;
      chk("midrun_rst_outputs", 64'(|{o_user_data, o_user_rd_ack, o_str_ack, o_lbuf_wr_en,
          o_lbuf_wr_addr, o_lbuf_rd_en, o_lbuf_rd_addr, o_out_valid, o_out_data, o_intr_req}), 0);
      @(posedge clk); #1;
      i_rst = 1'b0; i_str_valid = '0;
      model_reset();
      apply_stimulus();
      reg_read(20'h4, v);
      chk("status_after_rst", v, 32'h0);
      reg_read(20'h8, v);
      chk("outcnt_after_rst", v, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
